// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding and
// the oversampling / framing constants.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned MID_SAMPLE = 8;

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator.
// Pulses tick for one clk every CLK_HZ/(BAUD*16) clks; clear holds the
// divider at zero so the first tick after release is a full period away.
// Ports: clk, rst (async, active high), clear (restart), tick (registered).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Divider next state
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with 16x oversampling and mid-bit sampling.
// Ports: clk, rst (async, active high), uart_rx (async serial line, idle
// high); data_out (last good byte, feeds the command bus: [7:4] ALU A
// operand, [3:2] ALU select), data_valid / frame_err (1-clk pulses),
// parity_err (1-clk pulse, parity build only), busy (FSM not IDLE).
// Optional feature macro: UART_RX_PARITY_EN (8E1 with even-parity check).
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q;
  logic                 tick;
  logic                 tick_clr_c;
  logic                 fall_c;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  // Falling edge seen on the synchronized line
  assign fall_c = prev_q & ~sync2_q;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr_c),
    .tick  (tick)
  );

  // Next-state and pulse decode
  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    tick_clr_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = 1'b0;
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        // Divider held in reset so it restarts on leaving IDLE
        tick_clr_c = 1'b1;
        os_d       = '0;
        bit_d      = '0;
        if (fall_c) state_d = START;
      end
      START: begin
        if (tick) begin
          if (os_q == OS_W'(MID_SAMPLE - 1)) begin
            os_d    = '0;
            // Line back high at mid start bit: treat as a glitch
            state_d = sync2_q ? IDLE : DATA;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d      = '0;
            // Even parity: data bits plus parity bit must have even weight
            par_bad_d = sync2_q ^ (^shift_q);
            state_d   = STOP;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d = '0;
            if (sync2_q) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_d = 1'b1;
              end else begin
                valid_d = 1'b1;
                data_d  = shift_q;
              end
`else
              valid_d = 1'b1;
              data_d  = shift_q;
`endif
            end else begin
              // Bad stop bit outranks any parity result
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off through a break until the line is released
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, synchronizer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios plus a
// randomized frame stream checked against a frame-level reference model.
// Honours UART_RX_PARITY_EN when defined.
module tb_uart_byte_rx;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int          BIT_CLKS = int'((CLK_HZ / (BAUD * 16)) * 16);

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  wire        parity_err_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_byte_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err_w),
`endif
    .busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err_w = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every pulse, sampled away from the active edge
  logic [7:0] rx_q[$];
  int n_valid = 0, n_ferr = 0, n_perr = 0;
  int excl_viol = 0, long_pulse = 0, last_valid_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (data_valid === 1'b1) begin
        rx_q.push_back(data_out);
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err === 1'b1)    n_ferr++;
      if (parity_err_w === 1'b1) n_perr++;
      if ((int'(data_valid === 1'b1) + int'(frame_err === 1'b1) +
           int'(parity_err_w === 1'b1)) > 1) excl_viol++;
      if (data_valid === 1'b1 && prev_valid === 1'b1) long_pulse++;
      prev_valid = data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Reference model: even-parity bit for a byte
  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return logic'(ones % 2);
  endfunction

  // Reference model: 0 = good byte, 1 = framing error, 2 = parity error
  function automatic int outcome(input logic [7:0] b, input logic stop_v,
                                 input logic par_v);
    if (!stop_v) return 1;
`ifdef UART_RX_PARITY_EN
    if (par_v != even_par(b)) return 2;
`else
    if (par_v && 1'b0) return 2;
`endif
    return 0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  int start_cyc = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input logic par_v);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`else
    if (par_v && 1'b0) send_bit(1'b0);
`endif
    send_bit(stop_v);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    uart_rx = 1'b1;
    wait_clks(5);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    wait_clks(BIT_CLKS);
    total++; if (busy !== 1'b0 || n_valid != 0) begin bad++; $display("FAIL idle_after_reset: busy %b valids %0d want 0 0", busy, n_valid); end
  endtask

  task automatic test_good_frame;
    int v0 = n_valid;
    int lat;
    int lo = BIT_CLKS * 19 / 2;
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    uart_rx = 1'b1;
    wait_clks(4);
    lat = last_valid_cyc - start_cyc;
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL good_count: got %0d want 1", n_valid - v0); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL good_data: got %h want a5", data_out); end
    total++; if (long_pulse != 0) begin bad++; $display("FAIL good_pulse_width: got %0d long pulses want 0", long_pulse); end
    total++; if (lat < lo || lat > lo + 24) begin bad++; $display("FAIL good_latency: got %0d want %0d..%0d", lat, lo, lo + 24); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    int v0 = n_valid;
    int f0 = n_ferr;
    uart_rx = 1'b0;
    wait_clks(100);
    uart_rx = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", busy); end
    // Returns to IDLE at the mid start-bit sample, 8 ticks in
    wait_clks(160);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle: got %b want 0", busy); end
    wait_clks(BIT_CLKS);
    total++; if (n_valid != v0 || n_ferr != f0) begin bad++; $display("FAIL glitch_pulses: valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0); end
  endtask

  task automatic test_frame_err;
    int v0 = n_valid;
    int f0 = n_ferr;
    send_frame(8'h11, 1'b1, even_par(8'h11));
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    // Line held low as a break after the bad stop bit
    uart_rx = 1'b0;
    wait_clks(2 * BIT_CLKS);
    total++; if (n_ferr - f0 != ((outcome(8'h3C, 1'b0, even_par(8'h3C)) == 1) ? 1 : 0)) begin bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
    total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL ferr_valid_count: got %0d want 1", n_valid - v0); end
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ferr_data_held: got %h want 11", data_out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
    uart_rx = 1'b1;
    wait_clks(10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int idx = rx_q.size();
    int v0 = n_valid;
    send_frame(8'h00, 1'b1, even_par(8'h00));
    send_frame(8'hFF, 1'b1, even_par(8'hFF));
    uart_rx = 1'b1;
    wait_clks(10);
    total++; if (n_valid - v0 != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n_valid - v0); end
    if (n_valid - v0 == 2) begin
      total++; if (rx_q[idx] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", rx_q[idx]); end
      total++; if (rx_q[idx+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", rx_q[idx+1]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b = 8'h5A;
    int v0, f0;
    uart_rx = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    uart_rx = b[4];
    repeat (BIT_CLKS / 2) @(posedge clk);
    rst = 1'b1;
    wait_clks(3);
    total++; if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs: data %h valid %b ferr %b busy %b want 00 0 0 0", data_out, data_valid, frame_err, busy);
    end
    uart_rx = 1'b1;
    wait_clks(3);
    v0 = n_valid;
    f0 = n_ferr;
    rst = 1'b0;
    wait_clks(BIT_CLKS);
    total++; if (n_valid != v0 || n_ferr != f0) begin bad++; $display("FAIL midreset_no_pulse: valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0); end
    send_frame(8'hC3, 1'b1, even_par(8'hC3));
    uart_rx = 1'b1;
    wait_clks(4);
    total++; if (n_valid - v0 != 1 || data_out !== 8'hC3) begin bad++; $display("FAIL midreset_next: count %0d data %h want 1 c3", n_valid - v0, data_out); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0 = n_valid;
    int p0 = n_perr;
    logic [7:0] held = data_out;
    send_frame(8'h07, 1'b1, 1'b0);
    uart_rx = 1'b1;
    wait_clks(4);
    total++; if (n_perr - p0 != 1) begin bad++; $display("FAIL parity_err_count: got %0d want 1", n_perr - p0); end
    total++; if (n_valid != v0 || data_out !== held) begin bad++; $display("FAIL parity_suppress: valid %0d data %h want 0 %h", n_valid - v0, data_out, held); end
    send_frame(8'h07, 1'b1, 1'b1);
    uart_rx = 1'b1;
    wait_clks(4);
    total++; if (n_valid - v0 != 1 || data_out !== 8'h07) begin bad++; $display("FAIL parity_good: count %0d data %h want 1 07", n_valid - v0, data_out); end
  endtask
`endif

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b, last_good;
    logic stop_v, par_v;
    int exp_f = 0, exp_p = 0;
    int idx = rx_q.size();
    int f0 = n_ferr, p0 = n_perr, v0 = n_valid;
    last_good = data_out;
    for (int n = 0; n < 6; n++) begin
      b      = 8'($urandom);
      stop_v = ($urandom_range(0, 3) != 0);
      par_v  = even_par(b);
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 3) == 0) par_v = ~par_v;
`endif
      case (outcome(b, stop_v, par_v))
        0: begin exp_q.push_back(b); last_good = b; end
        1: exp_f++;
        default: exp_p++;
      endcase
      send_frame(b, stop_v, par_v);
      uart_rx = 1'b1;
      if (!stop_v) repeat (BIT_CLKS) @(posedge clk);
      else if ($urandom_range(0, 1) == 1) repeat (BIT_CLKS / 2) @(posedge clk);
    end
    uart_rx = 1'b1;
    wait_clks(10);
    total++; if (n_valid - v0 != exp_q.size()) begin bad++; $display("FAIL rand_valid_count: got %0d want %0d", n_valid - v0, exp_q.size()); end
    total++; if (n_ferr - f0 != exp_f) begin bad++; $display("FAIL rand_ferr_count: got %0d want %0d", n_ferr - f0, exp_f); end
    total++; if (n_perr - p0 != exp_p) begin bad++; $display("FAIL rand_perr_count: got %0d want %0d", n_perr - p0, exp_p); end
    for (int i = 0; i < exp_q.size() && idx + i < rx_q.size(); i++) begin
      total++; if (rx_q[idx+i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[idx+i], exp_q[i]); end
    end
    total++; if (data_out !== last_good) begin bad++; $display("FAIL rand_data_held: got %h want %h", data_out, last_good); end
    total++; if (excl_viol != 0 || long_pulse != 0) begin bad++; $display("FAIL rand_pulse_rules: overlap %0d long %0d want 0 0", excl_viol, long_pulse); end
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    test_reset;
    test_good_frame;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
